// File: rtl/decoder_scan_if.sv
// decoder_scan_if: address handshake and line-select bus of decoder_scan.
// The control side (master) supplies enable, mode and addresses; the
// decoder (slave) returns ready, the one-hot lines and scan status.
interface decoder_scan_if #(
  parameter int N = 2
);
  logic                en;
  logic                mode;
  logic [N-1:0]        A;
  logic                a_valid;
  logic                a_ready;
  logic [(1<<N)-1:0]   D;
  logic                D_valid;
  logic [N-1:0]        scan_idx;
  logic                wrap;

  modport master (
    output en, mode, A, a_valid,
    input  a_ready, D, D_valid, scan_idx, wrap
  );

  modport slave (
    input  en, mode, A, a_valid,
    output a_ready, D, D_valid, scan_idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot line decoder.
// Direct mode decodes addresses captured by a valid/ready handshake.
// Optional scan mode (macro DECODER_SCAN_EN) walks the one-hot output
// across every line, holding each for DWELL cycles, and pulses wrap when
// the sweep returns to line 0. Without the macro, mode is ignored and
// scan_idx/wrap are tied low.
module decoder_scan #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_if.slave  bus
);
  localparam int W  = 1 << N;
  localparam int CW = $clog2(DWELL) + 1;

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1} state_t;
`endif

  state_t         state_r, state_s;
  logic [W-1:0]   d_r, d_s;
  logic           d_valid_r, d_valid_s;

`ifdef DECODER_SCAN_EN
  logic [N-1:0]   idx_r, idx_s;
  logic [N-1:0]   idx_inc_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           wrap_r, wrap_s;

  // Next scan index wraps naturally at N bits.
  assign idx_inc_s = idx_r + N'(1);

  // Next-state and next-output decision for all three states.
  always_comb begin
    state_s   = state_r;
    d_s       = d_r;
    d_valid_s = d_valid_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    wrap_s    = 1'b0;
    if (!bus.en) begin
      state_s   = IDLE;
      d_s       = {W{1'b0}};
      d_valid_s = 1'b0;
      idx_s     = {N{1'b0}};
      cnt_s     = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.mode) begin
            state_s   = SCAN;
            d_s       = W'(1);
            d_valid_s = 1'b1;
            idx_s     = {N{1'b0}};
            cnt_s     = CW'(DWELL - 1);
          end else begin
            state_s   = DIRECT;
            d_s       = {W{1'b0}};
            d_valid_s = 1'b0;
          end
        end
        DIRECT: begin
          // A same-cycle accept is overridden by the scan entry load.
          if (bus.mode) begin
            state_s   = SCAN;
            d_s       = W'(1);
            d_valid_s = 1'b1;
            idx_s     = {N{1'b0}};
            cnt_s     = CW'(DWELL - 1);
          end else if (bus.a_valid) begin
            d_s       = W'(1) << bus.A;
            d_valid_s = 1'b1;
          end else begin
            d_s       = d_r;
            d_valid_s = d_valid_r;
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            // Leave scan blanked; D stays zero until the first accept.
            state_s   = DIRECT;
            d_s       = {W{1'b0}};
            d_valid_s = 1'b0;
            idx_s     = {N{1'b0}};
            cnt_s     = {CW{1'b0}};
          end else if (cnt_r == {CW{1'b0}}) begin
            idx_s  = idx_inc_s;
            d_s    = W'(1) << idx_inc_s;
            cnt_s  = CW'(DWELL - 1);
            wrap_s = (idx_inc_s == {N{1'b0}});
          end else begin
            cnt_s = cnt_r - CW'(1);
          end
        end
        default: begin
          state_s   = IDLE;
          d_s       = {W{1'b0}};
          d_valid_s = 1'b0;
          idx_s     = {N{1'b0}};
          cnt_s     = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      d_r       <= {W{1'b0}};
      d_valid_r <= 1'b0;
      idx_r     <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      wrap_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      d_r       <= d_s;
      d_valid_r <= d_valid_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      wrap_r    <= wrap_s;
    end
  end

  assign bus.scan_idx = idx_r;
  assign bus.wrap     = wrap_r;
`else
  logic unused_s;

  // Mode and dwell only matter when scan is compiled in.
  assign unused_s = bus.mode ^ (DWELL < 1);

  // Next-state and next-output decision for direct-only operation.
  always_comb begin
    state_s   = state_r;
    d_s       = d_r;
    d_valid_s = d_valid_r;
    if (!bus.en) begin
      state_s   = IDLE;
      d_s       = {W{1'b0}};
      d_valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s   = DIRECT;
          d_s       = {W{1'b0}};
          d_valid_s = 1'b0;
        end
        DIRECT: begin
          if (bus.a_valid) begin
            d_s       = W'(1) << bus.A;
            d_valid_s = 1'b1;
          end else begin
            d_s       = d_r;
            d_valid_s = d_valid_r;
          end
        end
        default: begin
          state_s   = IDLE;
          d_s       = {W{1'b0}};
          d_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      d_r       <= {W{1'b0}};
      d_valid_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      d_r       <= d_s;
      d_valid_r <= d_valid_s;
    end
  end

  assign bus.scan_idx = {N{1'b0}};
  assign bus.wrap     = 1'b0;
`endif

  assign bus.a_ready = (state_r == DIRECT);
  assign bus.D       = d_r;
  assign bus.D_valid = d_valid_r;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed scenarios plus randomized traffic for
// decoder_scan (N=2, DWELL=3), checked every cycle against a behavioural
// model that derives the scan line from elapsed cycles since scan entry.
module tb_decoder_scan;
  localparam int N     = 2;
  localparam int DWELL = 3;
  localparam int LINES = 1 << N;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  decoder_scan_if #(.N(N)) bus ();

  decoder_scan #(.N(N), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=idle, 1=direct, 2=scan; scan position is cycles since entry.
  int         m_st   = 0;
  int         m_t    = 0;
  logic [3:0] m_d    = 4'd0;
  logic       m_dv   = 1'b0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_t = 0; m_d = 4'd0; m_dv = 1'b0; m_live = 1'b1;
    end else if (!bus.en) begin
      m_st = 0; m_t = 0; m_d = 4'd0; m_dv = 1'b0;
    end else if (m_st == 0) begin
      if (SCAN_ON && bus.mode) begin m_st = 2; m_t = 0; end
      else begin m_st = 1; m_d = 4'd0; m_dv = 1'b0; end
    end else if (m_st == 1) begin
      if (SCAN_ON && bus.mode) begin m_st = 2; m_t = 0; end
      else if (bus.a_valid) begin m_d = 4'd1 << bus.A; m_dv = 1'b1; end
    end else begin
      if (!bus.mode) begin m_st = 1; m_d = 4'd0; m_dv = 1'b0; end
      else m_t++;
    end
  end

  // Compare DUT outputs to the model on every falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      int line;
      line = (m_t / DWELL) % LINES;
      check("a_ready", {31'd0, bus.a_ready}, {31'd0, m_st == 1});
      check("onehot", {31'd0, $countones(bus.D) <= 1}, 32'd1);
      if (m_st == 2) begin
        check("D_scan", {28'd0, bus.D}, 32'd1 << line);
        check("D_valid_scan", {31'd0, bus.D_valid}, 32'd1);
        check("scan_idx", {30'd0, bus.scan_idx}, line);
        check("wrap", {31'd0, bus.wrap}, {31'd0, (m_t > 0) && (m_t % (DWELL * LINES) == 0)});
      end else begin
        check("D", {28'd0, bus.D}, {28'd0, m_d});
        check("D_valid", {31'd0, bus.D_valid}, {31'd0, m_dv});
        check("wrap_off", {31'd0, bus.wrap}, 32'd0);
        if (!SCAN_ON || m_st == 0)
          check("scan_idx_off", {30'd0, bus.scan_idx}, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [3:0] d, input logic dv);
    check(name, {28'd0, bus.D}, {28'd0, d});
    check({name, "_v"}, {31'd0, bus.D_valid}, {31'd0, dv});
  endtask

  logic [3:0] sweep [13];

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.mode = 1'b0; bus.a_valid = 1'b1; bus.A = 2'd1;
    // Reset held two cycles with enable and valid active.
    for (int i = 0; i < 2; i++) begin
      cyc();
      pin("rst_D", 4'b0000, 1'b0);
      check("rst_ready", {31'd0, bus.a_ready}, 32'd0);
      check("rst_wrap", {31'd0, bus.wrap}, 32'd0);
    end
    rst = 1'b0; bus.a_valid = 1'b0;
    cyc();
    pin("post_rst_D", 4'b0000, 1'b0);
    check("post_rst_wrap", {31'd0, bus.wrap}, 32'd0);

    // Back-to-back direct accepts.
    bus.a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.A = 2'(i);
      cyc();
      pin("direct_D", 4'd1 << i, 1'b1);
    end
    bus.a_valid = 1'b0;
    cyc(); pin("direct_hold1", 4'b1000, 1'b1);
    cyc(); pin("direct_hold2", 4'b1000, 1'b1);

`ifdef DECODER_SCAN_EN
    // Full sweep: each line three cycles, then wrap to line 0.
    sweep = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
              4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    bus.mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      pin("sweep_D", sweep[i], 1'b1);
      check("sweep_wrap", {31'd0, bus.wrap}, {31'd0, i == 12});
    end
    // Leave scan mid-line, then accept A=2.
    bus.mode = 1'b0;
    cyc(); pin("switch_D", 4'b0000, 1'b0);
    bus.a_valid = 1'b1; bus.A = 2'd2;
    cyc(); pin("switch_acc", 4'b0100, 1'b1);
    bus.a_valid = 1'b0;
    // Blank by en on the second cycle of line 2, then by rst.
    for (int k = 0; k < 2; k++) begin
      bus.mode = 1'b1;
      cyc(); pin("rescan_D", 4'b0001, 1'b1);
      for (int i = 0; i < 7; i++) cyc();
      pin("line2_D", 4'b0100, 1'b1);
      if (k == 0) bus.en = 1'b0; else rst = 1'b1;
      cyc(); pin("blank_D", 4'b0000, 1'b0);
      check("blank_idx", {30'd0, bus.scan_idx}, 32'd0);
      bus.en = 1'b1; rst = 1'b0;
      cyc(); pin("restart_D", 4'b0001, 1'b1);
      check("restart_idx", {30'd0, bus.scan_idx}, 32'd0);
    end
    bus.mode = 1'b0;
    cyc();
`else
    // Mode is ignored: accept of A=3 decodes normally.
    bus.mode = 1'b1; bus.a_valid = 1'b1; bus.A = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pin("noscan_D", 4'b1000, 1'b1);
      check("noscan_idx", {30'd0, bus.scan_idx}, 32'd0);
      check("noscan_wrap", {31'd0, bus.wrap}, 32'd0);
    end
    bus.mode = 1'b0; bus.a_valid = 1'b0;
    cyc();
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.en      = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 29) == 0) bus.mode = ~bus.mode;
      bus.a_valid = $urandom_range(0, 1) == 1;
      bus.A       = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot line decoder. It replaces the fixed combinational 2-to-4 decoder built from two 1-to-2 stages. A valid/ready handshake captures addresses in direct mode. An optional scan mode steps the one-hot output through every line automatically, for multiplexed display and bank-select strobing. It sits between a control FSM, which supplies addresses, and the line-select loads.

## Interface
Parameters:
- N, default 2: address width; output width is 2^N.
- DWELL, default 4: cycles each line stays active in scan mode; must be ≥1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; 0 blanks the output.
- mode  in  1  0 = direct, 1 = scan (scan only if DECODER_SCAN_EN is defined).
- A  in  N  address to decode.
- a_valid  in  1  A is valid this cycle.
- a_ready  out  1  block accepts A this cycle.
- D  out  2^N  registered one-hot output.
- D_valid  out  1  D holds a decoded line.
- scan_idx  out  N  index of the active line in scan mode.
- wrap  out  1  one-cycle pulse when scan returns to line 0.

## Operation
- States: IDLE, DIRECT, SCAN.
- Priority within a cycle, highest first: rst > en=0 > mode change > accept or scan step.
- IDLE:
  - D=0, D_valid=0, a_ready=0.
  - en=1 with mode=0 → DIRECT.
  - en=1 with mode=1 → SCAN.
- DIRECT:
  - a_ready=1 combinationally.
  - Accept = a_valid & a_ready; registers D = 1<<A and D_valid=1.
  - With no accept, D and D_valid hold.
  - Back-to-back accepts update D every cycle.
- SCAN:
  - a_ready=0.
  - Entry edge loads D=1, scan_idx=0, D_valid=1, dwell counter = DWELL-1.
  - The counter decrements each cycle. On the cycle it is 0: scan_idx increments mod 2^N, D = 1<<scan_idx_next, and the counter reloads DWELL-1.
  - wrap=1 for exactly the cycle in which D changes from line 2^N-1 to line 0.
- Transitions:
  - en=0 in any state → IDLE next edge; D, D_valid, wrap, scan_idx, counter clear.
  - SCAN with mode=0 → DIRECT; D=0 and D_valid=0 until the first accept. An accept cannot occur on the switching cycle because a_ready=0 there.
  - DIRECT with mode=1 → SCAN. Any a_valid on that cycle is still accepted, but D is overwritten by the scan entry load (line 0).
- Arithmetic:
  - One-hot shift is of width 2^N.
  - Scan index wraps naturally at N bits.
  - Counter width is $clog2(DWELL)+1.
- D is always one-hot or zero, never multi-hot.

## Timing
- Reset (synchronous, takes effect at the edge rst is sampled high):
  - state=IDLE, D=0, D_valid=0, a_ready=0, scan_idx=0, wrap=0, counter=0.
- Reset mid-scan or mid-transfer discards all state. No partial line may remain on D.
- Direct latency: accept on edge t → D valid after edge t (visible at cycle t+1).
- Scan period: each line is held exactly DWELL cycles. A full sweep is DWELL·2^N cycles.
- DWELL=1: D advances every cycle, and wrap asserts every 2^N cycles.
- en, mode and a_valid are sampled only at clock edges. There is no combinational path from A to D.

## Configuration
- DECODER_SCAN_EN defined:
  - SCAN state, dwell counter, scan_idx and wrap logic are compiled in.
  - mode=1 behaves as described above.
- Undefined:
  - SCAN state is absent and mode is ignored; en=1 always goes to DIRECT.
  - scan_idx is tied 0 and wrap is tied 0.
  - Direct-mode timing is unchanged.

## Test plan
All scenarios use N=2, DWELL=3.
- Reset: hold rst 2 cycles with en=1 and a_valid=1 → D=4'b0000, D_valid=0, a_ready=0, wrap=0 during and 1 cycle after reset.
- Direct decode: en=1, mode=0, present A=0,1,2,3 back-to-back with a_valid=1 → D=0001,0010,0100,1000 on consecutive cycles, each one cycle after its accept. D holds 1000 once a_valid drops.
- Scan sweep (macro defined): en=1, mode=1 → D=0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each, then 0001 with wrap=1 for that single cycle. scan_idx tracks the active line.
- Mode switch: switch to scan mid-line, then back to mode=0 → D=0000 and D_valid=0 the cycle after the switch. The next accept of A=2 → D=0100.
- Blank and reset mid-scan: drop en on the second cycle of line 2 → D=0000 on the next cycle. Re-enable → scan restarts at line 0. Repeat with rst instead of en → same outcome.
- Build without DECODER_SCAN_EN: mode=1 plus accept of A=3 → D=1000; scan_idx=0 and wrap=0 throughout.
